// File: rtl/scene_pkg.sv
// Shared scene-controller encodings: FSM states, gate bit positions and renderer tile IDs.
// Pure definitions, no logic.
package scene_pkg;

  typedef enum logic [3:0] {
    S_START = 4'h0,
    S_PLAY  = 4'h1,
    S_LOSE  = 4'h2,
    S_WIN   = 4'h3,
    S_PAUSE = 4'h4
  } state_t;

  localparam int GATE1_BIT = 4;
  localparam int GATE2_BIT = 3;
  localparam int GATE3_BIT = 2;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;
  localparam logic [2:0] TILE_SPIKE = 3'd2;
  localparam logic [2:0] TILE_EXIT  = 3'd3;
  localparam logic [2:0] TILE_PLATE = 3'd4;
  localparam logic [2:0] TILE_GATE  = 3'd5;

  function automatic logic is_end_state(state_t s);
    return (s == S_LOSE) || (s == S_WIN);
  endfunction

endpackage

// File: rtl/scene_anim_frame_ctr.sv
// Per-player sprite-strip frame counter, stepping once every ANIM_DIV ticks while run is high.
// Updates only on tick; no backpressure.
module anim_frame_ctr #(
  parameter int IDLE_FRAMES = 4,
  parameter int WALK_FRAMES = 6,
  parameter int ANIM_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       moving,
  output logic [2:0] frame_idx
);

  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [DW-1:0] div;
  logic          prev_moving;
  logic [2:0]    last_frame;

  assign last_frame = moving ? 3'(WALK_FRAMES - 1) : 3'(IDLE_FRAMES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      prev_moving <= 1'b0;
      frame_idx   <= '0;
    end else if (tick) begin
      prev_moving <= moving;
      // A walk/idle switch restarts the new strip from its first frame.
      if (!run || (moving != prev_moving)) begin
        div       <= '0;
        frame_idx <= '0;
      end else if (div == DW'(ANIM_DIV - 1)) begin
        div       <= '0;
        frame_idx <= (frame_idx >= last_frame) ? 3'd0 : frame_idx + 3'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous scene FSM, gate timers and animation counters; SCENE_PAUSE_EN adds btn_pause/PAUSE.
// Outputs change only on the clk after frame_tick (3 clk after vsync rises); no backpressure.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int IDLE_FRAMES = 4,
  parameter int WALK_FRAMES = 6,
  parameter int ANIM_DIV    = 8,
  parameter int GATE_HOLD   = 120,
  parameter int END_HOLD    = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_start,
`ifdef SCENE_PAUSE_EN
  input  logic       btn_pause,
`endif
  input  logic       p0_moving,
  input  logic       p1_moving,
  input  logic       p0_on_spike,
  input  logic       p1_on_spike,
  input  logic       p0_at_exit,
  input  logic       p1_at_exit,
  input  logic [2:0] plate_hit,
  output logic [3:0] state,
  output logic [4:0] gate_open,
  output logic [2:0] frame_idx,
  output logic [2:0] frame_idx_1,
  output logic       frame_tick
);

  localparam int TW = $clog2(GATE_HOLD + 1);
  localparam int EW = $clog2(END_HOLD + 1);

  state_t        state_q;
  logic          vs_s1, vs_s2, vs_d;
  logic          start_pend;
  logic          pause_req;
  logic [EW-1:0] end_cnt;
  logic [TW-1:0] gate_tmr [3];
  logic [2:0]    g_open;
  logic          lose_hit, win_hit, stay_play, pause_enter, freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_d       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= vsync;
      vs_s2      <= vs_s1;
      vs_d       <= vs_s2;
      frame_tick <= vs_s2 & ~vs_d;
    end
  end

  // Every tick either uses or drops a pending press, so pendings clear on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_pend <= 1'b0;
    else     start_pend <= btn_start | (start_pend & ~frame_tick);
  end

`ifdef SCENE_PAUSE_EN
  logic pause_pend;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_pend <= 1'b0;
    else     pause_pend <= btn_pause | (pause_pend & ~frame_tick);
  end
  assign pause_req = pause_pend;
`else
  assign pause_req = 1'b0;
`endif

  assign lose_hit    = p0_on_spike | p1_on_spike;
  assign win_hit     = p0_at_exit & p1_at_exit;
  assign stay_play   = (state_q == S_PLAY) && !lose_hit && !win_hit && !pause_req;
  assign pause_enter = (state_q == S_PLAY) && !lose_hit && !win_hit && pause_req;
  assign freeze      = pause_enter || (state_q == S_PAUSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_START;
      end_cnt <= '0;
    end else if (frame_tick) begin
      end_cnt <= '0;
      case (state_q)
        S_START: if (start_pend) state_q <= S_PLAY;
        S_PLAY: begin
          if (lose_hit)       state_q <= S_LOSE;
          else if (win_hit)   state_q <= S_WIN;
          else if (pause_req) state_q <= S_PAUSE;
        end
        S_LOSE, S_WIN: begin
          if (start_pend || (end_cnt == EW'(END_HOLD - 1))) state_q <= S_START;
          else                                               end_cnt <= end_cnt + 1'b1;
        end
        S_PAUSE: if (pause_req) state_q <= S_PLAY;
        default: state_q <= S_START;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) gate_tmr[i] <= '0;
      g_open <= '0;
    end else if (frame_tick) begin
      if (stay_play) begin
        for (int i = 0; i < 3; i++) begin
          if (plate_hit[i]) begin
            g_open[i]   <= 1'b1;
            gate_tmr[i] <= TW'(GATE_HOLD);
          end else if (gate_tmr[i] > TW'(1)) begin
            gate_tmr[i] <= gate_tmr[i] - 1'b1;
          end else if (gate_tmr[i] == TW'(1)) begin
            gate_tmr[i] <= '0;
            g_open[i]   <= 1'b0;
          end
        end
      end else if (!freeze) begin
        for (int i = 0; i < 3; i++) gate_tmr[i] <= '0;
        g_open <= '0;
      end
    end
  end

  always_comb begin
    gate_open            = '0;
    gate_open[GATE1_BIT] = g_open[0];
    gate_open[GATE2_BIT] = g_open[1];
    gate_open[GATE3_BIT] = g_open[2];
  end

  assign state = state_q;

  anim_frame_ctr #(
    .IDLE_FRAMES(IDLE_FRAMES), .WALK_FRAMES(WALK_FRAMES), .ANIM_DIV(ANIM_DIV)
  ) u_anim_p0 (
    .clk(clk), .rst(rst), .tick(frame_tick & ~freeze), .run(stay_play),
    .moving(p0_moving), .frame_idx(frame_idx)
  );

  anim_frame_ctr #(
    .IDLE_FRAMES(IDLE_FRAMES), .WALK_FRAMES(WALK_FRAMES), .ANIM_DIV(ANIM_DIV)
  ) u_anim_p1 (
    .clk(clk), .rst(rst), .tick(frame_tick & ~freeze), .run(stay_play),
    .moving(p1_moving), .frame_idx(frame_idx_1)
  );

endmodule

// File: tb/tb_scene_sequencer.sv
// Scoreboard bench for scene_sequencer: expected per-frame values are queued with the stimulus
// and popped once the DUT has applied that frame's update.
module tb_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       btn_start = 1'b0;
`ifdef SCENE_PAUSE_EN
  logic       btn_pause = 1'b0;
`endif
  logic       p0_moving = 1'b0, p1_moving = 1'b0;
  logic       p0_on_spike = 1'b0, p1_on_spike = 1'b0;
  logic       p0_at_exit = 1'b0, p1_at_exit = 1'b0;
  logic [2:0] plate_hit = 3'b000;
  logic [3:0] state;
  logic [4:0] gate_open;
  logic [2:0] frame_idx, frame_idx_1;
  logic       frame_tick;

  int         chk_cnt = 0;
  int         fail_cnt = 0;
  int         last_lat = 0;
  logic [3:0] st_at_tick;
  logic [11:0] exp_q[$];

  scene_sequencer dut (
    .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start),
`ifdef SCENE_PAUSE_EN
    .btn_pause(btn_pause),
`endif
    .p0_moving(p0_moving), .p1_moving(p1_moving),
    .p0_on_spike(p0_on_spike), .p1_on_spike(p1_on_spike),
    .p0_at_exit(p0_at_exit), .p1_at_exit(p1_at_exit),
    .plate_hit(plate_hit), .state(state), .gate_open(gate_open),
    .frame_idx(frame_idx), .frame_idx_1(frame_idx_1), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // One video frame: raise vsync, wait (bounded) for frame_tick, let the update edge pass.
  task automatic run_frame();
    int n;
    n = 0;
    vsync = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 10);
    last_lat   = n;
    st_at_tick = state;
    if (frame_tick !== 1'b1) begin
      chk_cnt++;
      fail_cnt++;
      $display("FAIL frame_tick_timeout got %b want 1", frame_tick);
    end
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({state, gate_open, frame_idx, frame_idx_1, frame_tick} !== 16'h0) begin
      fail_cnt++;
      $display("FAIL reset_state got st=%0d gate=%b f0=%0d f1=%0d tick=%b want all 0",
               state, gate_open, frame_idx, frame_idx_1, frame_tick);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(12'h000);
      run_frame();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({state, gate_open, frame_idx} !== e) begin
        fail_cnt++;
        $display("FAIL idle_frame%0d got st=%0d gate=%b f0=%0d want %h", k, state, gate_open,
                 frame_idx, e);
      end
    end
  endtask

  task automatic test_tick();
    run_frame();
    chk_cnt++;
    if (last_lat != 3) begin
      fail_cnt++;
      $display("FAIL tick_latency got %0d want 3", last_lat);
    end
    chk_cnt++;
    if (frame_tick !== 1'b0) begin
      fail_cnt++;
      $display("FAIL tick_width got %b want 0", frame_tick);
    end
  endtask

  task automatic test_start();
    logic [11:0] e;
    repeat (2) @(negedge clk);
    press_start();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (state !== 4'd0) begin
      fail_cnt++;
      $display("FAIL start_early got %0d want 0", state);
    end
    exp_q.push_back(12'd1);
    run_frame();
    e = exp_q.pop_front();
    chk_cnt++;
    if (st_at_tick !== 4'd0) begin
      fail_cnt++;
      $display("FAIL start_at_tick got %0d want 0", st_at_tick);
    end
    chk_cnt++;
    if ({8'd0, state} !== e) begin
      fail_cnt++;
      $display("FAIL start_play got %0d want %0d", state, e);
    end
  endtask

  task automatic test_anim();
    logic [11:0] e;
    p0_moving = 1'b1;
    exp_q.push_back(12'd0);
    run_frame();
    e = exp_q.pop_front();
    chk_cnt++;
    if ({9'd0, frame_idx} !== e) begin
      fail_cnt++;
      $display("FAIL anim_walk_start got %0d want %0d", frame_idx, e);
    end
    for (int j = 1; j <= 88; j++) begin
      exp_q.push_back(12'((j / 8) % 6));
      run_frame();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({9'd0, frame_idx} !== e) begin
        fail_cnt++;
        $display("FAIL anim_walk_t%0d got %0d want %0d", j, frame_idx, e);
      end
    end
    p0_moving = 1'b0;
    exp_q.push_back(12'd0);
    run_frame();
    e = exp_q.pop_front();
    chk_cnt++;
    if ({9'd0, frame_idx} !== e) begin
      fail_cnt++;
      $display("FAIL anim_stop got %0d want %0d", frame_idx, e);
    end
    for (int i = 1; i <= 40; i++) begin
      exp_q.push_back(12'((i / 8) % 4));
      run_frame();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({9'd0, frame_idx} !== e) begin
        fail_cnt++;
        $display("FAIL anim_idle_t%0d got %0d want %0d", i, frame_idx, e);
      end
    end
  endtask

  task automatic test_gate();
    logic [11:0] e;
    plate_hit = 3'b001;
    exp_q.push_back(12'b10000);
    run_frame();
    plate_hit = 3'b000;
    e = exp_q.pop_front();
    chk_cnt++;
    if ({7'd0, gate_open} !== e) begin
      fail_cnt++;
      $display("FAIL gate1_open got %b want %b", gate_open, e[4:0]);
    end
    for (int k = 1; k <= 121; k++) begin
      exp_q.push_back((k < 120) ? 12'b10000 : 12'b00000);
      run_frame();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({7'd0, gate_open} !== e) begin
        fail_cnt++;
        $display("FAIL gate1_hold_t%0d got %b want %b", k, gate_open, e[4:0]);
      end
    end
    plate_hit = 3'b110;
    exp_q.push_back(12'b01100);
    run_frame();
    plate_hit = 3'b000;
    e = exp_q.pop_front();
    chk_cnt++;
    if ({7'd0, gate_open} !== e) begin
      fail_cnt++;
      $display("FAIL gate23_open got %b want %b", gate_open, e[4:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    exp_q.push_back({4'd1, 5'b01100, 3'd0});
    run_frame();
    e = exp_q.pop_front();
    chk_cnt++;
    if ({state, gate_open} !== e[11:3]) begin
      fail_cnt++;
      $display("FAIL pre_reset got st=%0d gate=%b want st=%0d gate=%b", state, gate_open,
               e[11:8], e[7:3]);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({state, gate_open, frame_idx, frame_idx_1} !== 15'h0) begin
      fail_cnt++;
      $display("FAIL async_reset got st=%0d gate=%b f0=%0d f1=%0d want all 0", state,
               gate_open, frame_idx, frame_idx_1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lose();
    logic [11:0] e;
    press_start();
    exp_q.push_back(12'd1);
    run_frame();
    e = exp_q.pop_front();
    chk_cnt++;
    if ({8'd0, state} !== e) begin
      fail_cnt++;
      $display("FAIL lose_enter_play got %0d want %0d", state, e);
    end
    press_start();
    exp_q.push_back(12'd1);
    run_frame();
    e = exp_q.pop_front();
    chk_cnt++;
    if ({8'd0, state} !== e) begin
      fail_cnt++;
      $display("FAIL play_start_ignored got %0d want %0d", state, e);
    end
    p0_on_spike = 1'b1;
    p0_at_exit  = 1'b1;
    p1_at_exit  = 1'b1;
    exp_q.push_back(12'd2);
    run_frame();
    p0_on_spike = 1'b0;
    p0_at_exit  = 1'b0;
    p1_at_exit  = 1'b0;
    e = exp_q.pop_front();
    chk_cnt++;
    if ({8'd0, state} !== e) begin
      fail_cnt++;
      $display("FAIL lose_priority got %0d want %0d", state, e);
    end
    for (int k = 1; k <= 180; k++) begin
      exp_q.push_back((k < 180) ? 12'd2 : 12'd0);
      run_frame();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({8'd0, state} !== e) begin
        fail_cnt++;
        $display("FAIL lose_hold_t%0d got %0d want %0d", k, state, e);
      end
    end
  endtask

  task automatic test_win();
    logic [11:0] e;
    logic [3:0] seq [4];
    seq[0] = 4'd1; seq[1] = 4'd3; seq[2] = 4'd3; seq[3] = 4'd0;
    for (int s = 0; s < 4; s++) begin
      if (s == 0 || s == 3) press_start();
      p0_at_exit = (s == 1);
      p1_at_exit = (s == 1);
      exp_q.push_back({8'd0, seq[s]});
      run_frame();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({8'd0, state} !== e) begin
        fail_cnt++;
        $display("FAIL win_step%0d got %0d want %0d", s, state, e);
      end
    end
    p0_at_exit = 1'b0;
    p1_at_exit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_start();
    test_anim();
    test_gate();
    test_reset_mid();
    test_lose();
    test_win();
    $display("%0d/%0d checks passed", chk_cnt - fail_cnt, chk_cnt);
    $finish;
  end

endmodule
